// File: rtl/lstm_step_sequencer.sv
// ============================================================================
// lstm_step_sequencer: timestep controller for an LSTM cell and its ROM bank.
// Rev 1.0
// ============================================================================
`default_nettype none

module lstm_step_sequencer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int ADDR_BASE = 0,
  parameter int SEQ_LEN   = 16,
  parameter int ROM_LAT   = 1,
  parameter int CELL_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_first,
  output logic              in_ready,
  input  logic              abort,
  input  logic              of_clr,
  input  logic [DATA_W-1:0] lstm_hout,
  input  logic [DATA_W-1:0] lstm_cout,
  input  logic              lstm_of,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cen,
  output logic              lstm_cen,
  output logic [DATA_W-1:0] lstm_in,
  output logic [DATA_W-1:0] prev_h,
  output logic [DATA_W-1:0] prev_c,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] step_idx,
  output logic              busy,
  output logic              of_sticky
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_COMPUTE = 3'd2,
    S_WB      = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic [ADDR_W-1:0] t;
  logic              last_step;
  logic              accept;

  assign last_step = (t == ADDR_W'(SEQ_LEN - 1));
  assign accept    = (state == S_IDLE) && in_valid && !abort;
  assign rom_addr  = ADDR_W'(ADDR_BASE) + t;
  assign step_idx  = t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    rom_cen   = 1'b0;
    lstm_cen  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) begin
          state_nxt = S_FETCH;
          cnt_nxt   = '0;
        end
      end
      S_FETCH: begin
        rom_cen = 1'b1;
        if (cnt == 16'(ROM_LAT - 1)) begin
          state_nxt = S_COMPUTE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_COMPUTE: begin
        // ROM stays enabled so its outputs are held while the cell runs
        rom_cen  = 1'b1;
        lstm_cen = 1'b1;
        if (cnt == 16'(CELL_LAT - 1)) begin
          state_nxt = S_WB;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_WB: begin
        state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_last  = last_step;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t        <= '0;
      lstm_in  <= '0;
      prev_h   <= '0;
      prev_c   <= '0;
      out_data <= '0;
    end else if (abort) begin
      t      <= '0;
      prev_h <= '0;
      prev_c <= '0;
    end else begin
      if (accept) begin
        lstm_in <= in_data;
        if (in_first) begin
          t      <= '0;
          prev_h <= '0;
          prev_c <= '0;
        end
      end
      if (state == S_WB) begin
        prev_h   <= lstm_hout;
        prev_c   <= lstm_cout;
        out_data <= lstm_hout;
      end
      if (state == S_OUT && out_ready) begin
        if (last_step) begin
          t      <= '0;
          prev_h <= '0;
          prev_c <= '0;
        end else begin
          t <= t + 1'b1;
        end
      end
    end
  end

  // A writeback overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      of_sticky <= 1'b0;
    end else if (state == S_WB && lstm_of) begin
      of_sticky <= 1'b1;
    end else if (of_clr) begin
      of_sticky <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lstm_step_sequencer.sv
// ============================================================================
// tb_lstm_step_sequencer: randomized self-checking bench with reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lstm_step_sequencer;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int ADDR_BASE = 0;
  localparam int SEQ_LEN   = 16;
  localparam int ROM_LAT   = 1;
  localparam int CELL_LAT  = 2;
  localparam int LAT       = ROM_LAT + CELL_LAT + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_first = 1'b0;
  logic              in_ready;
  logic              abort = 1'b0;
  logic              of_clr = 1'b0;
  logic [DATA_W-1:0] lstm_hout = '0;
  logic [DATA_W-1:0] lstm_cout = '0;
  logic              lstm_of = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_cen;
  logic              lstm_cen;
  logic [DATA_W-1:0] lstm_in;
  logic [DATA_W-1:0] prev_h;
  logic [DATA_W-1:0] prev_c;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] step_idx;
  logic              busy;
  logic              of_sticky;

  lstm_step_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_BASE(ADDR_BASE),
    .SEQ_LEN(SEQ_LEN), .ROM_LAT(ROM_LAT), .CELL_LAT(CELL_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_first(in_first), .in_ready(in_ready), .abort(abort), .of_clr(of_clr),
    .lstm_hout(lstm_hout), .lstm_cout(lstm_cout), .lstm_of(lstm_of),
    .rom_addr(rom_addr), .rom_cen(rom_cen), .lstm_cen(lstm_cen),
    .lstm_in(lstm_in), .prev_h(prev_h), .prev_c(prev_c),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .step_idx(step_idx), .busy(busy),
    .of_sticky(of_sticky)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model of sequence position and carried state
  int         mt  = 0;
  logic [7:0] mh  = '0;
  logic [7:0] mc  = '0;
  logic       mof = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_step(input logic first, input logic [7:0] x, input logic [7:0] hout,
                         input logic [7:0] cout, input logic of, input int hold);
    int k, ncen, nrom;
    logic last;
    @(negedge clk);
    in_valid = 1'b1; in_first = first; in_data = x;
    chk("in_ready_idle", in_ready, 1);
    if (first) begin mt = 0; mh = '0; mc = '0; end
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0;
    lstm_hout = hout; lstm_cout = cout; lstm_of = of;
    chk("busy_fetch", busy, 1);
    chk("in_ready_busy", in_ready, 0);
    chk("rom_addr", rom_addr, ADDR_BASE + mt);
    chk("lstm_in", lstm_in, x);
    chk("prev_h_use", prev_h, mh);
    chk("prev_c_use", prev_c, mc);
    k = 1; ncen = 0; nrom = 0;
    while (!out_valid && k < 20) begin
      ncen += int'(lstm_cen);
      nrom += int'(rom_cen);
      @(negedge clk);
      k++;
    end
    chk("latency", k - 1, LAT);
    chk("lstm_cen_cycles", ncen, CELL_LAT);
    chk("rom_cen_cycles", nrom, ROM_LAT + CELL_LAT);
    mof  = mof | of;
    last = (mt == SEQ_LEN - 1);
    chk("out_data", out_data, hout);
    chk("out_last", out_last, last);
    chk("prev_h_wb", prev_h, hout);
    chk("prev_c_wb", prev_c, cout);
    chk("of_sticky", of_sticky, mof);
    chk("step_idx_out", step_idx, mt);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hout);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_cens", {rom_cen, lstm_cen}, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (last) begin mt = 0; mh = '0; mc = '0; end
    else begin mt++; mh = hout; mc = cout; end
    chk("out_valid_drop", out_valid, 0);
    chk("step_idx_next", step_idx, mt);
    chk("prev_h_next", prev_h, mh);
  endtask

  initial begin
    int vlost;
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rom_addr", rom_addr, ADDR_BASE);
    chk("rst_outs", {rom_cen, lstm_cen, out_valid, out_last, of_sticky}, 0);
    chk("rst_data", {lstm_in, prev_h, prev_c, out_data}, 0);
    rst_n = 1'b1;

    // directed first step
    do_step(1'b1, 8'h10, 8'h22, 8'h05, 1'b0, 0);

    // rest of a full sequence with overflow at step 3, backpressure at step 7
    for (int i = 1; i < SEQ_LEN; i++)
      do_step(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), (i == 3), (i == 7) ? 10 : 0);

    @(negedge clk); of_clr = 1'b1;
    @(negedge clk); of_clr = 1'b0; mof = 1'b0;
    chk("of_clr", of_sticky, 0);

    // randomized traffic including mid-sequence restarts
    for (int i = 0; i < 24; i++)
      do_step(($urandom_range(7) == 0), 8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(3) == 0), $urandom_range(2));

    // abort during FETCH at t=5
    for (int i = 0; i < 5; i++)
      do_step((i == 0), 8'($urandom), 8'($urandom), 8'($urandom), (i == 2), 0);
    @(negedge clk);
    in_valid = 1'b1; in_first = 1'b0; in_data = 8'h5a;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_t5", step_idx, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; mt = 0; mh = '0; mc = '0;
    chk("abort_busy", busy, 0);
    chk("abort_step", step_idx, 0);
    chk("abort_prev", {prev_h, prev_c}, 0);
    chk("abort_of_kept", of_sticky, mof);
    vlost = 0;
    repeat (6) begin
      @(negedge clk);
      vlost += int'(out_valid) + int'(lstm_cen);
    end
    chk("abort_quiet", vlost, 0);

    // abort beats in_valid in IDLE
    @(negedge clk);
    in_valid = 1'b1; abort = 1'b1; in_data = 8'h77;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_ready", in_ready, 1);

    // asynchronous reset mid-COMPUTE
    do_step(1'b1, 8'h31, 8'h41 | 8'($urandom), 8'h0f, 1'b1, 0);
    @(negedge clk);
    in_valid = 1'b1; in_first = 1'b0; in_data = 8'h99;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_compute", lstm_cen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_prev", {prev_h, prev_c}, 0);
    chk("arst_outs", {rom_cen, lstm_cen, out_valid, of_sticky}, 0);
    chk("arst_step", step_idx, 0);
    @(negedge clk);
    rst_n = 1'b1; mt = 0; mh = '0; mc = '0; mof = 1'b0;
    do_step(1'b0, 8'h12, 8'h34, 8'h56, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
